nn_layer_sequencer: RTL and testbench

Sequences one fully-connected layer of the PL neural net.
- Reads pixels from the image BRAM and weights from the weight BRAM (both written over AXI-lite).
- Runs multiply-accumulate per neuron, adds the per-neuron bias from the bias register file and applies optional ReLU.
- Streams one 32-bit result per neuron on the AXI-stream output "a", with tlast on the final neuron.
- Sits between the AXI-lite register/BRAM block and the downstream stream consumer, and is triggered by start.

---
 rtl/nn_layer_sequencer_if.sv | 42 ++++
 rtl/nn_layer_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if
//   Bundles everything that crosses the boundary of the layer sequencer,
//   except clock and reset:
//     control : start (in), busy / done (out)
//     image   : img_addr / img_en (out), img_rdata (in, 1-cycle latency)
//     weight  : w_addr / w_en (out), w_rdata (in, 1-cycle latency)
//     bias    : bias_idx (out), bias_data (in, combinational)
//     stream  : a_tdata / a_tvalid / a_tlast (out), a_tready (in)
//   master = the sequencer, slave = the surrounding memories and consumer.
interface nn_layer_sequencer_if #(
  parameter int PIX_ADDR_W = 10,
  parameter int W_ADDR_W   = 14,
  parameter int NEURON_W   = 4
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [PIX_ADDR_W-1:0] img_addr;
  logic                  img_en;
  logic [7:0]            img_rdata;
  logic [W_ADDR_W-1:0]   w_addr;
  logic                  w_en;
  logic [7:0]            w_rdata;
  logic [NEURON_W-1:0]   bias_idx;
  logic [31:0]           bias_data;
  logic [31:0]           a_tdata;
  logic                  a_tvalid;
  logic                  a_tready;
  logic                  a_tlast;

  modport master (
    input  start, img_rdata, w_rdata, bias_data, a_tready,
    output busy, done, img_addr, img_en, w_addr, w_en, bias_idx,
           a_tdata, a_tvalid, a_tlast
  );

  modport slave (
    output start, img_rdata, w_rdata, bias_data, a_tready,
    input  busy, done, img_addr, img_en, w_addr, w_en, bias_idx,
           a_tdata, a_tvalid, a_tlast
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
//   Runs one fully-connected layer: for each neuron it streams N_INPUTS
//   pixel/weight pairs out of the image and weight BRAMs, accumulates
//   unsigned-pixel x signed-weight products, adds the neuron's bias,
//   optionally clamps negatives to zero (RELU) and emits the 32-bit result
//   as one AXI-stream beat, with tlast on the final neuron.
//   Ports: ACLK (rising edge), ARESETN (async assert, active low), and the
//   nn_layer_sequencer_if master modport carrying control, BRAM read,
//   bias lookup and output stream signals.
module nn_layer_sequencer #(
  parameter int N_INPUTS   = 784,
  parameter int N_NEURONS  = 10,
  parameter int PIX_ADDR_W = 10,
  parameter int W_ADDR_W   = 14,
  parameter int NEURON_W   = 4,
  parameter bit RELU       = 1'b1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  nn_layer_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_BIAS  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [PIX_ADDR_W-1:0] LAST_K  = PIX_ADDR_W'(N_INPUTS - 1);
  localparam logic [NEURON_W-1:0]   LAST_N  = NEURON_W'(N_NEURONS - 1);
  localparam logic [PIX_ADDR_W-1:0] PIX_ONE = PIX_ADDR_W'(1);
  localparam logic [W_ADDR_W-1:0]   W_ONE   = W_ADDR_W'(1);
  localparam logic [NEURON_W-1:0]   N_ONE   = NEURON_W'(1);

  state_e                state_q, state_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PIX_ADDR_W-1:0] img_addr_q, img_addr_d;
  logic [W_ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic                  en_q, en_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [NEURON_W-1:0]   bias_idx_q, bias_idx_d;
  logic [31:0]           acc_q, acc_d;
  logic [31:0]           a_tdata_q, a_tdata_d;
  logic                  a_tvalid_q, a_tvalid_d;
  logic                  a_tlast_q, a_tlast_d;

  logic                  start_rise_s;
  logic                  hs_s;
  logic signed [16:0]    pix_s;
  logic signed [16:0]    wt_s;
  logic signed [16:0]    prod_s;
  logic [31:0]           prod_ext_s;
  logic [31:0]           sum_s;
  logic                  clamp_s;

  assign start_rise_s = bus.start & ~start_q;
  assign hs_s         = a_tvalid_q & bus.a_tready;

  // Pixel is unsigned, so it gets a zero top bit before the signed multiply.
  assign pix_s      = 17'($signed({1'b0, bus.img_rdata}));
  assign wt_s       = 17'($signed(bus.w_rdata));
  assign prod_s     = pix_s * wt_s;
  assign prod_ext_s = 32'(prod_s);

  // Bias add wraps in 32 bits; no saturation.
  assign sum_s   = acc_q + bus.bias_data;
  assign clamp_s = RELU & sum_s[31];

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      img_addr_q <= '0;
      w_addr_q   <= '0;
      en_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      bias_idx_q <= '0;
      acc_q      <= 32'd0;
      a_tdata_q  <= 32'd0;
      a_tvalid_q <= 1'b0;
      a_tlast_q  <= 1'b0;
    end else begin
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      img_addr_q <= img_addr_d;
      w_addr_q   <= w_addr_d;
      en_q       <= en_d;
      rd_valid_q <= rd_valid_d;
      bias_idx_q <= bias_idx_d;
      acc_q      <= acc_d;
      a_tdata_q  <= a_tdata_d;
      a_tvalid_q <= a_tvalid_d;
      a_tlast_q  <= a_tlast_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (img_addr_q == LAST_K) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: state_d = S_BIAS;
      S_BIAS:  state_d = S_OUT;
      S_OUT: begin
        if (hs_s) begin
          if (a_tlast_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register-next values for addresses, accumulator and stream outputs.
  always_comb begin
    start_d    = bus.start;
    busy_d     = busy_q;
    done_d     = 1'b0;
    img_addr_d = img_addr_q;
    w_addr_d   = w_addr_q;
    en_d       = en_q;
    // Read data is valid exactly one cycle after an enabled address.
    rd_valid_d = en_q;
    bias_idx_d = bias_idx_q;
    a_tdata_d  = a_tdata_q;
    a_tvalid_d = a_tvalid_q;
    a_tlast_d  = a_tlast_q;
    if (rd_valid_q) begin
      acc_d = acc_q + prod_ext_s;
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_rise_s) begin
          busy_d     = 1'b1;
          img_addr_d = '0;
          w_addr_d   = '0;
          bias_idx_d = '0;
          en_d       = 1'b1;
          acc_d      = 32'd0;
        end else begin
          busy_d = busy_q;
        end
      end
      S_FETCH: begin
        if (img_addr_q == LAST_K) begin
          en_d = 1'b0;
        end else begin
          img_addr_d = img_addr_q + PIX_ONE;
          w_addr_d   = w_addr_q + W_ONE;
        end
      end
      S_DRAIN: begin
        en_d = 1'b0;
      end
      S_BIAS: begin
        if (clamp_s) begin
          a_tdata_d = 32'd0;
        end else begin
          a_tdata_d = sum_s;
        end
        a_tlast_d  = (bias_idx_q == LAST_N);
        a_tvalid_d = 1'b1;
      end
      S_OUT: begin
        if (hs_s) begin
          a_tvalid_d = 1'b0;
          a_tlast_d  = 1'b0;
          if (!a_tlast_q) begin
            // Weight address keeps running across neurons; pixels restart.
            bias_idx_d = bias_idx_q + N_ONE;
            acc_d      = 32'd0;
            img_addr_d = '0;
            w_addr_d   = w_addr_q + W_ONE;
            en_d       = 1'b1;
          end else begin
            en_d = 1'b0;
          end
        end else begin
          a_tvalid_d = a_tvalid_q;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
        en_d   = 1'b0;
      end
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.img_addr = img_addr_q;
  assign bus.img_en   = en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_en     = en_q;
  assign bus.bias_idx = bias_idx_q;
  assign bus.a_tdata  = a_tdata_q;
  assign bus.a_tvalid = a_tvalid_q;
  assign bus.a_tlast  = a_tlast_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: two instances (RELU=1 and RELU=0) share the
// clock, reset and memory contents; a monitor on the selected instance
// records beats, addresses and done pulses, and a reference model computes
// every expected result from the memory contents with plain arithmetic.
module tb_nn_layer_sequencer;

  localparam int NI  = 4;
  localparam int NN  = 3;
  localparam int PAW = 4;
  localparam int WAW = 6;
  localparam int NW  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  bit   sel0;          // 0 = RELU=1 instance, 1 = RELU=0 instance
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   accept_cyc;

  logic [7:0]  img_mem  [0:15];
  logic [7:0]  wt_mem   [0:63];
  logic [31:0] bias_mem [0:15];

  nn_layer_sequencer_if #(.PIX_ADDR_W(PAW), .W_ADDR_W(WAW), .NEURON_W(NW)) bus1 ();
  nn_layer_sequencer_if #(.PIX_ADDR_W(PAW), .W_ADDR_W(WAW), .NEURON_W(NW)) bus0 ();

  nn_layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .PIX_ADDR_W(PAW),
                       .W_ADDR_W(WAW), .NEURON_W(NW), .RELU(1'b1))
    u_dut1 (.ACLK(clk), .ARESETN(rst_n), .bus(bus1));

  nn_layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .PIX_ADDR_W(PAW),
                       .W_ADDR_W(WAW), .NEURON_W(NW), .RELU(1'b0))
    u_dut0 (.ACLK(clk), .ARESETN(rst_n), .bus(bus0));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle BRAM models and combinational bias file
  always @(posedge clk) begin
    if (bus1.img_en) bus1.img_rdata <= img_mem[bus1.img_addr];
    if (bus1.w_en)   bus1.w_rdata   <= wt_mem[bus1.w_addr];
    if (bus0.img_en) bus0.img_rdata <= img_mem[bus0.img_addr];
    if (bus0.w_en)   bus0.w_rdata   <= wt_mem[bus0.w_addr];
  end
  assign bus1.bias_data = bias_mem[bus1.bias_idx];
  assign bus0.bias_data = bias_mem[bus0.bias_idx];
  assign bus1.a_tready  = rdy;
  assign bus0.a_tready  = rdy;

  logic [31:0]    m_tdata;
  logic           m_valid, m_tlast, m_img_en, m_w_en, m_done, m_busy;
  logic [PAW-1:0] m_iaddr;
  logic [WAW-1:0] m_waddr;
  logic [NW-1:0]  m_bidx;
  assign m_tdata  = sel0 ? bus0.a_tdata  : bus1.a_tdata;
  assign m_valid  = sel0 ? bus0.a_tvalid : bus1.a_tvalid;
  assign m_tlast  = sel0 ? bus0.a_tlast  : bus1.a_tlast;
  assign m_img_en = sel0 ? bus0.img_en   : bus1.img_en;
  assign m_w_en   = sel0 ? bus0.w_en     : bus1.w_en;
  assign m_done   = sel0 ? bus0.done     : bus1.done;
  assign m_busy   = sel0 ? bus0.busy     : bus1.busy;
  assign m_iaddr  = sel0 ? bus0.img_addr : bus1.img_addr;
  assign m_waddr  = sel0 ? bus0.w_addr   : bus1.w_addr;
  assign m_bidx   = sel0 ? bus0.bias_idx : bus1.bias_idx;

  logic [31:0] beat_q[$];
  logic        last_q[$];
  int          bidx_q[$];
  int          hs_q[$];
  int          ia_q[$];
  int          wa_q[$];
  int          done_q[$];
  logic        busyd_q[$];
  int          rise_q[$];
  logic        prev_v = 1'b0;

  // Monitor on the falling edge, where everything is stable.
  always @(negedge clk) begin
    if (m_valid && rdy) begin
      beat_q.push_back(m_tdata);
      last_q.push_back(m_tlast);
      bidx_q.push_back(int'(m_bidx));
      hs_q.push_back(cyc);
    end
    if (m_img_en) begin
      ia_q.push_back(int'(m_iaddr));
      wa_q.push_back(int'(m_waddr));
    end
    if (m_done) begin
      done_q.push_back(cyc);
      busyd_q.push_back(m_busy);
    end
    if (m_valid && !prev_v) rise_q.push_back(cyc);
    prev_v <= m_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: dot product of unsigned pixels and signed weights plus bias,
  // 32-bit wrap, optional clamp.
  function automatic logic [31:0] model(input int n, input bit relu);
    int s;
    s = 0;
    for (int k = 0; k < NI; k++)
      s += int'(img_mem[k]) * int'($signed(wt_mem[n*NI + k]));
    s += int'(bias_mem[n]);
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic clear_mon();
    beat_q.delete(); last_q.delete(); bidx_q.delete(); hs_q.delete();
    ia_q.delete(); wa_q.delete(); done_q.delete(); busyd_q.delete();
    rise_q.delete();
  endtask

  task automatic set_start(input logic v);
    if (sel0) bus0.start = v;
    else      bus1.start = v;
  endtask

  task automatic start_pulse();
    accept_cyc = cyc + 1;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    rdy = 1'b1;
    chk("done_seen", 32'(done_q.size() != 0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_pass(input string tag, input bit relu, input bit timing);
    chk({tag, "_nbeats"}, 32'(beat_q.size()), 32'(NN));
    chk({tag, "_ndone"}, 32'(done_q.size()), 32'd1);
    if (busyd_q.size() > 0) chk({tag, "_busy_at_done"}, 32'(busyd_q[0]), 32'd0);
    for (int n = 0; n < NN; n++) begin
      if (n < beat_q.size()) begin
        chk($sformatf("%s_data%0d", tag, n), beat_q[n], model(n, relu));
        chk($sformatf("%s_last%0d", tag, n), 32'(last_q[n]), 32'(n == NN - 1));
        chk($sformatf("%s_bidx%0d", tag, n), 32'(bidx_q[n]), 32'(n));
      end
    end
    chk({tag, "_naddr"}, 32'(wa_q.size()), 32'(NI * NN));
    for (int i = 0; i < NI * NN; i++) begin
      if (i < wa_q.size()) begin
        chk($sformatf("%s_waddr%0d", tag, i), 32'(wa_q[i]), 32'(i));
        chk($sformatf("%s_iaddr%0d", tag, i), 32'(ia_q[i]), 32'(i % NI));
      end
    end
    if (timing && rise_q.size() == NN && hs_q.size() == NN && done_q.size() > 0) begin
      chk({tag, "_first_valid"}, 32'(rise_q[0]), 32'(accept_cyc + NI + 2));
      for (int n = 1; n < NN; n++)
        chk($sformatf("%s_period%0d", tag, n), 32'(rise_q[n] - rise_q[n-1]), 32'(NI + 3));
      chk({tag, "_done_time"}, 32'(done_q[0]), 32'(hs_q[NN-1] + 2));
    end
  endtask

  initial begin
    int n;
    logic [31:0] hold_d;
    logic        hold_l;
    bit          ok;

    rst_n = 1'b0; rdy = 1'b1; sel0 = 1'b0;
    bus1.start = 1'b0; bus0.start = 1'b0;
    for (int i = 0; i < 16; i++) begin img_mem[i] = 8'd0; bias_mem[i] = 32'd0; end
    for (int i = 0; i < 64; i++) wt_mem[i] = 8'd0;
    for (int k = 0; k < NI; k++) img_mem[k] = 8'(k + 1);
    for (int k = 0; k < NI; k++) begin
      wt_mem[k]      = 8'd1;
      wt_mem[NI + k] = 8'hFF;
    end
    wt_mem[8] = 8'd2; wt_mem[9] = 8'd0; wt_mem[10] = 8'd0; wt_mem[11] = 8'hFF;
    bias_mem[0] = 32'd5; bias_mem[1] = 32'd3; bias_mem[2] = 32'd100;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     32'(bus1.busy),     32'd0);
    chk("rst_done",     32'(bus1.done),     32'd0);
    chk("rst_img_en",   32'(bus1.img_en),   32'd0);
    chk("rst_w_en",     32'(bus1.w_en),     32'd0);
    chk("rst_tvalid",   32'(bus1.a_tvalid), 32'd0);
    chk("rst_tlast",    32'(bus1.a_tlast),  32'd0);
    chk("rst_img_addr", 32'(bus1.img_addr), 32'd0);
    chk("rst_w_addr",   32'(bus1.w_addr),   32'd0);
    chk("rst_bias_idx", 32'(bus1.bias_idx), 32'd0);
    chk("rst_tdata",    bus1.a_tdata,       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic pass with ready held high
    clear_mon();
    start_pulse();
    wait_done(200, 1'b0);
    check_pass("basic", 1'b1, 1'b1);
    if (beat_q.size() == NN) begin
      chk("basic_v0", beat_q[0], 32'd15);
      chk("basic_v1", beat_q[1], 32'd0);
      chk("basic_v2", beat_q[2], 32'd98);
    end

    // Backpressure: 10 stalled cycles on every beat
    clear_mon();
    rdy = 1'b0;
    start_pulse();
    for (int b = 0; b < NN; b++) begin
      rdy = 1'b0;
      n = 0;
      while (!m_valid && n < 60) begin @(posedge clk); #1; n++; end
      chk("stall_valid_seen", 32'(m_valid), 32'd1);
      hold_d = m_tdata; hold_l = m_tlast; ok = 1'b1;
      repeat (10) begin
        @(posedge clk); #1;
        if (m_tdata !== hold_d || m_tlast !== hold_l || m_valid !== 1'b1 ||
            m_img_en !== 1'b0 || m_w_en !== 1'b0) ok = 1'b0;
      end
      chk("stall_stable", 32'(ok), 32'd1);
      rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0;
    end
    rdy = 1'b1;
    wait_done(60, 1'b0);
    check_pass("stall", 1'b1, 1'b0);

    // RELU=0 instance
    sel0 = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    start_pulse();
    wait_done(200, 1'b0);
    check_pass("norelu", 1'b0, 1'b1);
    if (beat_q.size() > 1) chk("norelu_v1", beat_q[1], 32'hFFFF_FFF9);
    sel0 = 1'b0;
    @(posedge clk); #1;

    // start held high for 40 cycles gives exactly one pass
    clear_mon();
    accept_cyc = cyc + 1;
    set_start(1'b1);
    repeat (40) @(posedge clk);
    #1;
    set_start(1'b0);
    repeat (20) @(posedge clk);
    #1;
    check_pass("hold", 1'b1, 1'b1);

    // Second pulse mid-pass is ignored
    clear_mon();
    start_pulse();
    repeat (5) @(posedge clk);
    #1;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    wait_done(200, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check_pass("midpulse", 1'b1, 1'b1);

    // Fresh pulse after done repeats the pass
    clear_mon();
    start_pulse();
    wait_done(200, 1'b0);
    check_pass("again", 1'b1, 1'b1);

    // Reset during FETCH of neuron 1
    clear_mon();
    start_pulse();
    n = 0;
    while (hs_q.size() == 0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("rst_hs_seen", 32'(hs_q.size()), 32'd1);
    @(posedge clk); #1;
    chk("rst_in_fetch", 32'(bus1.img_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   32'(bus1.busy),     32'd0);
    chk("abort_tvalid", 32'(bus1.a_tvalid), 32'd0);
    chk("abort_img_en", 32'(bus1.img_en),   32'd0);
    chk("abort_w_en",   32'(bus1.w_en),     32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    start_pulse();
    wait_done(200, 1'b0);
    check_pass("postrst", 1'b1, 1'b1);
    if (beat_q.size() > 0) chk("postrst_v0", beat_q[0], 32'd15);

    // Random memories and random ready on both instances
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NI; k++) img_mem[k] = 8'($urandom);
      for (int k = 0; k < NI * NN; k++) wt_mem[k] = 8'($urandom);
      for (int j = 0; j < NN; j++) bias_mem[j] = $urandom;
      if (r < 2) bias_mem[1] = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
      sel0 = bit'(r % 2);
      @(posedge clk); #1;
      clear_mon();
      start_pulse();
      wait_done(400, 1'b1);
      check_pass($sformatf("rand%0d", r), (r % 2) == 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
